out_arb: RTL and testbench

OUT_ARB -- requirements
Module: out_arb

---
 rtl/out_arb.sv | 132 +++++++++++++
 tb/tb_out_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/out_arb.sv
// ============================================================================
// out_arb : round-robin arbiter for one output port; grants one requester,
//           forwards its payload and counts completed transfers.  Rev 1.0
// ============================================================================
`ifndef PKT_W
`define PKT_W 32
`endif
`default_nettype none

module out_arb #(
  parameter int PYLD_W = `PKT_W,
  parameter int N_IN   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN*PYLD_W-1:0]   payload_i,
  output logic [N_IN-1:0]          arb_gnt,
  input  logic                     obuf_rdy,
  output logic                     obuf_vld,
  output logic [PYLD_W-1:0]        payload_o,
  output logic [15:0]              xfer_cnt,
  output logic                     drop_err
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, ptr_after, gnt_idx;
  logic [N_IN-1:0]   gnt_nxt, pending;
  logic [15:0]       cnt_nxt;
  logic              err_nxt, hit;

  // First set bit of v, searching upward from p and wrapping at N_IN-1.
  function automatic logic [N_IN-1:0] rr_pick(input logic [N_IN-1:0]  v,
                                              input logic [PTR_W-1:0] p);
    logic [N_IN-1:0]  oh;
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      sum = {1'b0, p} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_IN)) sum = sum - (PTR_W+1)'(N_IN);
      idx = sum[PTR_W-1:0];
      if (!found && v[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    gnt_idx   = '0;
    payload_o = payload_i[PYLD_W-1:0];
    for (int i = 0; i < N_IN; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx   = PTR_W'(i);
        payload_o = payload_i[i*PYLD_W +: PYLD_W];
      end
    end
  end

  assign obuf_vld  = (state == GRANT);
  assign hit       = |(arb_gnt & req);
  // The winner's request is still visible during its transfer cycle.
  assign pending   = req & ~arb_gnt;
  assign ptr_after = (gnt_idx == PTR_W'(N_IN-1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = arb_gnt;
    ptr_nxt   = ptr;
    cnt_nxt   = xfer_cnt;
    err_nxt   = drop_err;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = rr_pick(req, ptr);
        end
      end
      GRANT: begin
        if (!hit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (obuf_rdy) begin
          ptr_nxt = ptr_after;
          cnt_nxt = xfer_cnt + 16'd1;
          if (|pending) begin
            gnt_nxt = rr_pick(pending, ptr_after);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      arb_gnt  <= '0;
      ptr      <= '0;
      xfer_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      arb_gnt  <= gnt_nxt;
      ptr      <= ptr_nxt;
      xfer_cnt <= cnt_nxt;
      drop_err <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_out_arb.sv
// ============================================================================
// tb_out_arb : directed scoreboard bench for out_arb.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_out_arb;

  localparam int N  = 5;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*PW-1:0] payload_i;
  logic [N-1:0]    arb_gnt;
  logic            obuf_rdy;
  logic            obuf_vld;
  logic [PW-1:0]   payload_o;
  logic [15:0]     xfer_cnt;
  logic            drop_err;

  out_arb #(.PYLD_W(PW), .N_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .payload_i (payload_i),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .obuf_vld  (obuf_vld),
    .payload_o (payload_o),
    .xfer_cnt  (xfer_cnt),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [PW-1:0] pay;
  } xfer_t;

  xfer_t         sb_q[$];
  logic [PW-1:0] pay_v [N];
  int            n_chk  = 0;
  int            n_fail = 0;

  logic          sb_en, chk, end_chk;
  logic [N-1:0]  e_gnt;
  logic          e_vld, e_err;
  logic [15:0]   e_cnt;
  logic [PW-1:0] e_pay;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks status snapshots.
  always @(negedge clk) begin
    xfer_t e;
    if (sb_en && obuf_vld === 1'b1 && obuf_rdy) begin
      if (sb_q.size() == 0) begin
        cmp("xfer_unexpected", {11'd0, arb_gnt, payload_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        cmp("xfer_gnt", 32'(arb_gnt), 32'(e.gnt));
        cmp("xfer_payload", 32'(payload_o), 32'(e.pay));
      end
    end
    if (chk) begin
      cmp("arb_gnt", 32'(arb_gnt), 32'(e_gnt));
      cmp("obuf_vld", 32'(obuf_vld), 32'(e_vld));
      cmp("xfer_cnt", 32'(xfer_cnt), 32'(e_cnt));
      cmp("drop_err", 32'(drop_err), 32'(e_err));
      if (e_vld) cmp("payload_o", 32'(payload_o), 32'(e_pay));
    end
    if (end_chk) cmp("sb_leftover", sb_q.size(), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic expect_st(input logic [N-1:0] g, input logic v, input logic [15:0] c,
                           input logic er, input int pi);
    e_gnt = g;
    e_vld = v;
    e_cnt = c;
    e_err = er;
    e_pay = pay_v[pi];
    chk   = 1'b1;
  endtask

  task automatic push(input logic [N-1:0] g, input int pi);
    sb_q.push_back({g, pay_v[pi]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, required finish within bound");
    $fatal(1, "watchdog");
  end

  initial begin
    pay_v[0] = 16'hA0A0; pay_v[1] = 16'hB1B1; pay_v[2] = 16'hC2C2;
    pay_v[3] = 16'hD3D3; pay_v[4] = 16'hE4E4;
    for (int i = 0; i < N; i++) payload_i[i*PW +: PW] = pay_v[i];
    rst_n = 1'b0; req = '0; obuf_rdy = 1'b0;
    sb_en = 1'b1; chk = 1'b0; end_chk = 1'b0;
    e_gnt = '0; e_vld = 1'b0; e_cnt = '0; e_err = 1'b0; e_pay = '0;
    repeat (3) step();
    expect_st(5'b00000, 0, 0, 0, 0); step();
    rst_n = 1'b1;

    // Single requester from reset
    req = 5'b00100; obuf_rdy = 1'b1; push(5'b00100, 2);
    expect_st(5'b00000, 0, 0, 0, 0); step();
    expect_st(5'b00100, 1, 0, 0, 2); step();
    req = 5'b00000; expect_st(5'b00000, 0, 1, 0, 0); step();

    // ptr=3: bit 3 first, then bit 0 back-to-back
    req = 5'b01001; push(5'b01000, 3); push(5'b00001, 0); step();
    step();
    req = 5'b00001; expect_st(5'b00001, 1, 2, 0, 0); step();
    req = 5'b00000; expect_st(5'b00000, 0, 3, 0, 0); step();

    // Winner 3 leaves ptr=4; then 01001 grants bit 0 then bit 3
    req = 5'b01000; push(5'b01000, 3); step();
    step();
    req = 5'b00000; expect_st(5'b00000, 0, 4, 0, 0); step();
    req = 5'b01001; push(5'b00001, 0); push(5'b01000, 3); step();
    step();
    req = 5'b01000; expect_st(5'b01000, 1, 5, 0, 3); step();
    req = 5'b00000; expect_st(5'b00000, 0, 6, 0, 0); step();

    // Backpressure for 10 cycles; a late request on bit 4 must not disturb the grant
    obuf_rdy = 1'b0; req = 5'b00010; step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) req = 5'b10010;
      expect_st(5'b00010, 1, 6, 0, 1); step();
    end
    obuf_rdy = 1'b1; push(5'b00010, 1); push(5'b10000, 4);
    expect_st(5'b00010, 1, 6, 0, 1); step();
    req = 5'b10000; expect_st(5'b10000, 1, 7, 0, 4); step();
    req = 5'b00000; expect_st(5'b00000, 0, 8, 0, 0); step();

    // Withdrawn request while stalled -> sticky drop_err
    obuf_rdy = 1'b0; req = 5'b00100; step();
    expect_st(5'b00100, 1, 8, 0, 2); step();
    req = 5'b00000; expect_st(5'b00100, 1, 8, 0, 2); step();
    expect_st(5'b00000, 0, 8, 1, 0); step();
    obuf_rdy = 1'b1; req = 5'b01100; push(5'b00100, 2); push(5'b01000, 3); step();
    step();
    req = 5'b01000; expect_st(5'b01000, 1, 9, 1, 3); step();
    req = 5'b00000; expect_st(5'b00000, 0, 10, 1, 0); step();

    // Reset in the middle of a grant
    obuf_rdy = 1'b0; req = 5'b00010; step();
    expect_st(5'b00010, 1, 10, 1, 1); rst_n = 1'b0; step();
    req = 5'b00000; expect_st(5'b00000, 0, 0, 0, 0); step();
    rst_n = 1'b1;

    // Full rotation with all requests held
    req = 5'b11111; obuf_rdy = 1'b1;
    push(5'b00001, 0); push(5'b00010, 1); push(5'b00100, 2);
    push(5'b01000, 3); push(5'b10000, 4); push(5'b00001, 0);
    expect_st(5'b00000, 0, 0, 0, 0); step();
    expect_st(5'b00001, 1, 0, 0, 0);
    repeat (6) step();
    obuf_rdy = 1'b0; expect_st(5'b00010, 1, 6, 0, 1); step();

    // Counter wrap: 65536 transfers in total
    sb_en = 1'b0; obuf_rdy = 1'b1;
    repeat (65530) step();
    obuf_rdy = 1'b0; expect_st(5'b00010, 1, 0, 0, 1); step();
    sb_en = 1'b1; end_chk = 1'b1; step();
    end_chk = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
